// File: rtl/costas_pll_pkg.sv
// costas_pll_pkg: shared widths, quarter-wave sine table, sine lookup
// and the error saturation used by the Costas loop.
package costas_pll_pkg;

  localparam int DIN_W = 8;
  localparam int MUL_W = 16;
  localparam int LPF_W = 20;
  localparam int PH_W  = 32;
  localparam int ERR_W = LPF_W + 1;

  // round(127*sin(2*pi*k/256)) for k = 0..64; the
  // other three quadrants follow by symmetry.
  localparam logic signed [DIN_W-1:0] SIN_Q [0:64] = '{
    8'sd0,   8'sd3,   8'sd6,   8'sd9,
    8'sd12,  8'sd16,  8'sd19,  8'sd22,
    8'sd25,  8'sd28,  8'sd31,  8'sd34,
    8'sd37,  8'sd40,  8'sd43,  8'sd46,
    8'sd49,  8'sd51,  8'sd54,  8'sd57,
    8'sd60,  8'sd63,  8'sd65,  8'sd68,
    8'sd71,  8'sd73,  8'sd76,  8'sd78,
    8'sd81,  8'sd83,  8'sd85,  8'sd88,
    8'sd90,  8'sd92,  8'sd94,  8'sd96,
    8'sd98,  8'sd100, 8'sd102, 8'sd104,
    8'sd106, 8'sd107, 8'sd109, 8'sd111,
    8'sd112, 8'sd113, 8'sd115, 8'sd116,
    8'sd117, 8'sd118, 8'sd120, 8'sd121,
    8'sd122, 8'sd122, 8'sd123, 8'sd124,
    8'sd125, 8'sd125, 8'sd126, 8'sd126,
    8'sd126, 8'sd127, 8'sd127, 8'sd127,
    8'sd127
  };

  // Full 256-entry sine from the quarter table:
  // bit 6 mirrors the index, bit 7 negates.
  function automatic logic signed [DIN_W-1:0] sin_lut(
    input logic [7:0] a
  );
    logic [6:0]              idx;
    logic signed [DIN_W-1:0] v;
    if (a[6])
      idx = 7'd64 - {1'b0, a[5:0]};
    else
      idx = {1'b0, a[5:0]};
    v = SIN_Q[idx];
    if (a[7])
      v = -v;
    return v;
  endfunction

  // Clamp a one-bit-wider value into LPF_W signed.
  function automatic logic signed [LPF_W-1:0] sat_lpf(
    input logic signed [ERR_W-1:0] x
  );
    logic signed [LPF_W-1:0] r;
    if (x[ERR_W-1] != x[LPF_W-1])
      r = x[ERR_W-1] ? {1'b1, {(LPF_W-1){1'b0}}}
                     : {1'b0, {(LPF_W-1){1'b1}}};
    else
      r = x[LPF_W-1:0];
    return r;
  endfunction

endpackage

// File: rtl/costas_pll_nco.sv
// pll_nco: 32-bit phase accumulator with sine/cosine lookup.
// Ports: clk, rst (sync, high), fw (frequency word) -> sin_val, cos_val.
module pll_nco
  import costas_pll_pkg::*;
(
  input  logic                    clk,
  input  logic                    rst,
  input  logic [PH_W-1:0]         fw,
  output logic signed [DIN_W-1:0] sin_val,
  output logic signed [DIN_W-1:0] cos_val
);

  logic [PH_W-1:0] phase;
  logic [7:0]      addr;

  always_ff @(posedge clk) begin
    if (rst)
      phase <= '0;
    else
      phase <= phase + fw;
  end

  assign addr    = phase[PH_W-1 -: 8];
  assign sin_val = sin_lut(addr);
  assign cos_val = sin_lut(addr + 8'd64);

endmodule

// File: rtl/costas_pll_top.sv
// costas_pll_top: BPSK Costas carrier-recovery loop, one sample per clk.
// Ports: clk, rst (sync, high), din (signed 8b sample) -> dout (hard bit).
module costas_pll_top
  import costas_pll_pkg::*;
#(
  parameter logic [PH_W-1:0] FW_NOM   = 32'h4000_0000,
  parameter int              DEC      = 16,
  parameter int              KP_SHIFT = 4,
  parameter int              KI_SHIFT = 10
)(
  input  logic             clk,
  input  logic             rst,
  input  logic [DIN_W-1:0] din,
  output logic             dout
);

  localparam int CNT_W = $clog2(DEC);

  logic [PH_W-1:0]          fw;
  logic signed [DIN_W-1:0]  sin_val;
  logic signed [DIN_W-1:0]  cos_val;
  logic signed [MUL_W-1:0]  din_x;
  logic signed [MUL_W-1:0]  sin_x;
  logic signed [MUL_W-1:0]  cos_x;
  logic signed [MUL_W-1:0]  multi_i_out;
  logic signed [MUL_W-1:0]  multi_q_out;
  logic                     mul_vld;
  logic [CNT_W-1:0]         cnt;
  logic                     last;
  logic signed [LPF_W-1:0]  acc_i;
  logic signed [LPF_W-1:0]  acc_q;
  logic signed [LPF_W-1:0]  sum_i;
  logic signed [LPF_W-1:0]  sum_q;
  logic signed [LPF_W-1:0]  lpf_i_out;
  logic signed [LPF_W-1:0]  lpf_q_out;
  logic                     lpf_ce;
  logic signed [ERR_W-1:0]  q_ext;
  logic signed [ERR_W-1:0]  err_raw;
  logic signed [LPF_W-1:0]  err;
  logic signed [PH_W-1:0]   err_ki;
  logic signed [PH_W-1:0]   err_kp;
  logic signed [PH_W-1:0]   integ;
  logic signed [PH_W-1:0]   integ_nxt;
  logic signed [PH_W-1:0]   loop_adj;

  assign fw = FW_NOM + $unsigned(loop_adj);

  pll_nco u_nco (
    .clk     (clk),
    .rst     (rst),
    .fw      (fw),
    .sin_val (sin_val),
    .cos_val (cos_val)
  );

  assign din_x = MUL_W'($signed(din));
  assign sin_x = MUL_W'(sin_val);
  assign cos_x = MUL_W'(cos_val);

  // mul_vld holds off the counter until the
  // first real product leaves the mixer.
  always_ff @(posedge clk) begin
    if (rst) begin
      multi_i_out <= '0;
      multi_q_out <= '0;
      mul_vld     <= 1'b0;
    end else begin
      multi_i_out <= din_x * cos_x;
      multi_q_out <= din_x * sin_x;
      mul_vld     <= 1'b1;
    end
  end

  assign last  = (cnt == CNT_W'(DEC - 1));
  assign sum_i = acc_i + LPF_W'(multi_i_out);
  assign sum_q = acc_q + LPF_W'(multi_q_out);

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt       <= '0;
      acc_i     <= '0;
      acc_q     <= '0;
      lpf_i_out <= '0;
      lpf_q_out <= '0;
      lpf_ce    <= 1'b0;
    end else begin
      lpf_ce <= 1'b0;
      if (mul_vld) begin
        if (last) begin
          cnt       <= '0;
          acc_i     <= '0;
          acc_q     <= '0;
          lpf_i_out <= sum_i;
          lpf_q_out <= sum_q;
          lpf_ce    <= 1'b1;
        end else begin
          cnt   <= cnt + CNT_W'(1);
          acc_i <= sum_i;
          acc_q <= sum_q;
        end
      end
    end
  end

  // Sign of I strips the BPSK data off Q; one
  // extra bit so negating -2^19 cannot wrap.
  assign q_ext   = ERR_W'(lpf_q_out);
  assign err_raw = lpf_i_out[LPF_W-1] ? q_ext : -q_ext;
  assign err     = sat_lpf(err_raw);

  assign err_ki    = PH_W'(err) >>> KI_SHIFT;
  assign err_kp    = PH_W'(err) >>> KP_SHIFT;
  assign integ_nxt = integ + err_ki;

  always_ff @(posedge clk) begin
    if (rst) begin
      integ    <= '0;
      loop_adj <= '0;
      dout     <= 1'b0;
    end else if (lpf_ce) begin
      integ    <= integ_nxt;
      loop_adj <= integ_nxt + err_kp;
      dout     <= ~lpf_i_out[LPF_W-1];
    end
  end

endmodule

// File: tb/tb_costas_pll_top.sv
// tb_costas_pll_top: randomized and directed stimulus for the Costas
// loop, checked every cycle against a sample-level reference model.
module tb_costas_pll_top;

  localparam int        PER  = 10;
  localparam logic [31:0] FWN = 32'h4000_0000;
  localparam real       PI   = 3.14159265358979323846;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] din = '0;
  logic       dout;

  always #(PER/2) clk = ~clk;

  costas_pll_top #(
    .FW_NOM   (FWN),
    .DEC      (16),
    .KP_SHIFT (4),
    .KI_SHIFT (10)
  ) dut (
    .clk  (clk),
    .rst  (rst),
    .din  (din),
    .dout (dout)
  );

  int n_cmp = 0;
  int n_err = 0;

  task automatic chk(input string nm, input longint act,
                     input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_err++;
      if (n_err <= 40)
        $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  // ---------------- reference model ----------------
  logic [31:0] m_ph;
  int          m_L, m_integ;
  int          m_pL, m_pI;
  bit          m_pD, m_pend;
  bit          m_ce, m_dout, m_mv;
  int          m_li, m_lq, m_mi, m_mq;
  int          wq_i[$];
  int          wq_q[$];

  function automatic int rnd(input real x);
    if (x >= 0.0) return int'($floor(x + 0.5));
    return -int'($floor(-x + 0.5));
  endfunction

  function automatic int tsin(input int a);
    return rnd(127.0 * $sin(2.0 * PI * real'(a) / 256.0));
  endfunction

  function automatic int floordiv(input int a, input int b);
    return int'($floor(real'(a) / real'(b)));
  endfunction

  function automatic int w20(input int x);
    logic signed [19:0] t;
    t = x[19:0];
    return int'(t);
  endfunction

  task automatic model_update(input bit r, input logic [7:0] d);
    bit apply;
    int a, sd, si, sq, e;
    if (r) begin
      m_ph = '0; m_L = 0; m_integ = 0; m_pend = 0;
      m_ce = 0; m_dout = 0; m_mv = 0; m_li = 0; m_lq = 0;
      wq_i.delete(); wq_q.delete();
      return;
    end
    apply  = m_pend;
    m_pend = 0;
    m_ce   = 0;
    if (m_mv) begin
      wq_i.push_back(m_mi);
      wq_q.push_back(m_mq);
      if (wq_i.size() == 16) begin
        si = 0; sq = 0;
        foreach (wq_i[k]) begin
          si += wq_i[k];
          sq += wq_q[k];
        end
        wq_i.delete(); wq_q.delete();
        m_li = w20(si);
        m_lq = w20(sq);
        m_ce = 1;
        e = (m_li >= 0) ? -m_lq : m_lq;
        if (e > 524287)  e = 524287;
        if (e < -524288) e = -524288;
        m_pI   = m_integ + floordiv(e, 1024);
        m_pL   = m_pI + floordiv(e, 16);
        m_pD   = (m_li >= 0);
        m_pend = 1;
      end
    end
    a    = int'(m_ph[31:24]);
    sd   = int'($signed(d));
    m_mi = sd * tsin((a + 64) % 256);
    m_mq = sd * tsin(a);
    m_mv = 1;
    m_ph = m_ph + FWN + m_L;
    if (apply) begin
      m_L     = m_pL;
      m_integ = m_pI;
      m_dout  = m_pD;
    end
  endtask

  task automatic compare_all();
    chk("lpf_ce", dut.lpf_ce, m_ce);
    chk("dout", dout, m_dout);
    chk("loop_adj", $signed(dut.loop_adj), m_L);
    if (m_mv) begin
      chk("multi_i", $signed(dut.multi_i_out), m_mi);
      chk("multi_q", $signed(dut.multi_q_out), m_mq);
    end
    if (m_ce) begin
      chk("lpf_i", $signed(dut.lpf_i_out), m_li);
      chk("lpf_q", $signed(dut.lpf_q_out), m_lq);
    end
  endtask

  task automatic step(input bit r, input int d);
    rst = r;
    din = 8'(d);
    @(posedge clk);
    model_update(r, 8'(d));
    @(negedge clk);
    compare_all();
  endtask

  // ---------------- stimulus ----------------
  int ip[4]  = '{100, 0, -100, 0};
  int inv[4] = '{-100, 0, 100, 0};
  int q90[4] = '{0, -100, 0, 100};

  initial begin
    #(PER * 300000);
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int first, nce, found, dumps, li, lq, b;
    logic [31:0] tph;

    // reset, then silence
    step(1, 0);
    chk("rst_dout", dout, 0);
    chk("rst_ce", dut.lpf_ce, 0);
    chk("rst_adj", $signed(dut.loop_adj), 0);
    first = -1; nce = 0;
    for (int k = 1; k <= 200; k++) begin
      step(0, 0);
      if (dut.lpf_ce) begin
        if (first < 0) first = k;
        nce++;
      end
    end
    chk("first_ce", first, 17);
    chk("ce_count", nce, 12);

    // in-phase carrier
    step(1, 0);
    for (int k = 0; k < 16 * 20 + 2; k++) begin
      step(0, ip[k % 4]);
      if (dut.lpf_ce) begin
        chk("ip_lpf_i", $signed(dut.lpf_i_out), 101600);
        chk("ip_lpf_q", $signed(dut.lpf_q_out), 0);
        chk("ip_model_i", m_li, 101600);
      end
    end
    chk("ip_dout", dout, 1);
    chk("ip_adj", $signed(dut.loop_adj), 0);

    // inverted carrier
    step(1, 0);
    for (int k = 0; k < 16 * 20 + 2; k++) begin
      step(0, inv[k % 4]);
      if (dut.lpf_ce)
        chk("inv_lpf_i", $signed(dut.lpf_i_out), -101600);
    end
    chk("inv_dout", dout, 0);
    chk("inv_adj", $signed(dut.loop_adj), 0);

    // 90 degree lead: pull-in toward lock
    step(1, 0);
    for (int k = 0; k < 17; k++)
      step(0, q90[k % 4]);
    chk("q90_lpf_i", $signed(dut.lpf_i_out), 0);
    chk("q90_lpf_q", $signed(dut.lpf_q_out), -101600);
    step(0, q90[17 % 4]);
    chk("q90_adj", $signed(dut.loop_adj), 6449);
    chk("q90_dout", dout, 1);
    found = 0; dumps = 1;
    for (int k = 18; k < 18 + 16 * 3000 && found == 0; k++) begin
      step(0, q90[k % 4]);
      if (dut.lpf_ce) begin
        dumps++;
        li = $signed(dut.lpf_i_out);
        lq = $signed(dut.lpf_q_out);
        if (li < 0) li = -li;
        if (lq < 0) lq = -lq;
        if (li > 0 && lq * 20 < li) found = 1;
      end
    end
    chk("q90_lock", found, 1);

    // random samples
    step(1, 0);
    for (int k = 0; k < 2000; k++)
      step(0, int'($urandom_range(255)));

    // BPSK with +1 kHz carrier offset
    step(1, 0);
    tph = '0; b = 1;
    for (int k = 0; k < 4000; k++) begin
      if (k % 16 == 0) b = ($urandom_range(1) == 1) ? 1 : -1;
      step(0, b * rnd(100.0 * $cos(2.0 * PI * real'(tph) / 4294967296.0)));
      tph = tph + FWN + 32'd268435;
    end

    // lock, then a one-cycle reset mid-window
    step(1, 0);
    for (int k = 0; k < 16 * 6 + 8; k++)
      step(0, ip[k % 4]);
    chk("pre_rst_dout", dout, 1);
    step(1, 0);
    chk("mid_rst_dout", dout, 0);
    chk("mid_rst_ce", dut.lpf_ce, 0);
    chk("mid_rst_lpf_i", $signed(dut.lpf_i_out), 0);
    chk("mid_rst_adj", $signed(dut.loop_adj), 0);
    first = -1;
    for (int k = 1; k <= 40 && first < 0; k++) begin
      step(0, ip[(k - 1) % 4]);
      if (dut.lpf_ce) first = k;
    end
    chk("mid_rst_first_ce", first, 17);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_err);
    $finish;
  end

endmodule
